// File: rtl/arbiter_4req.sv
// arbiter_4req: four-requester arbiter for one shared downstream resource.
// A request is granted, the grant is registered and held until the owner
// drops its request or the hold limit expires. The arbitration policy is
// either fixed priority (req[3] highest) or round-robin, chosen by 'mode'
// at each arbitration edge.
//
// Handshake: req[i] is a level request. Requester i owns the resource in
// every cycle where grant[i] is high. It releases the resource by dropping
// req[i]. A grant is never issued in the cycle right after a release or
// timeout, so there is always one idle cycle between two grants.
//
// MAX_HOLD must be in 1..255, because the hold counter is 8 bits wide.

module arbiter_4req #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mode,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] grant_id_nxt;
    logic       grant_valid_nxt;
    logic       timeout_nxt;

    logic [1:0] fixed_id;
    logic [1:0] rr_id;
    logic       rr_found;
    logic [1:0] win_id;
    logic       owner_req;

    // Fixed-priority winner: the highest set request index.
    always_comb begin
        fixed_id = 2'd0;
        if (req[3]) begin
            fixed_id = 2'd3;
        end else if (req[2]) begin
            fixed_id = 2'd2;
        end else if (req[1]) begin
            fixed_id = 2'd1;
        end else begin
            fixed_id = 2'd0;
        end
    end

    // Round-robin winner: scan ptr+1, ptr+2, ptr+3, ptr and take the first set bit.
    always_comb begin
        logic [1:0] idx;
        rr_id    = ptr;
        rr_found = 1'b0;
        idx      = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k + 1);
            if (!rr_found && req[idx]) begin
                rr_id    = idx;
                rr_found = 1'b1;
            end
        end
    end

    // The policy is applied only when arbitrating from IDLE, so a mode change
    // in the middle of a grant has no effect on that grant.
    always_comb begin
        win_id    = mode ? rr_id : fixed_id;
        owner_req = req[grant_id];
    end

    // Next-state and next-output logic. Every output is registered from these.
    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        ptr_nxt         = ptr;
        grant_nxt       = grant;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        timeout_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt       = BUSY;
                    grant_nxt       = 4'b0001 << win_id;
                    grant_id_nxt    = win_id;
                    grant_valid_nxt = 1'b1;
                    hold_cnt_nxt    = 8'd1;
                    ptr_nxt         = win_id;
                end else begin
                    grant_nxt       = 4'b0000;
                    grant_id_nxt    = 2'd0;
                    grant_valid_nxt = 1'b0;
                    hold_cnt_nxt    = 8'd0;
                end
            end

            BUSY: begin
                if (!owner_req) begin
                    // Voluntary release. This has priority over the limit, so
                    // dropping the request on the last allowed cycle is not a timeout.
                    state_nxt       = IDLE;
                    grant_nxt       = 4'b0000;
                    grant_id_nxt    = 2'd0;
                    grant_valid_nxt = 1'b0;
                    hold_cnt_nxt    = 8'd0;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    // Forced release after MAX_HOLD granted cycles.
                    state_nxt       = IDLE;
                    grant_nxt       = 4'b0000;
                    grant_id_nxt    = 2'd0;
                    grant_valid_nxt = 1'b0;
                    hold_cnt_nxt    = 8'd0;
                    timeout_nxt     = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt       = IDLE;
                grant_nxt       = 4'b0000;
                grant_id_nxt    = 2'd0;
                grant_valid_nxt = 1'b0;
                hold_cnt_nxt    = 8'd0;
            end
        endcase
    end

    // State and output registers. Reset drops any owner without a timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= 8'd0;
            ptr         <= 2'd3;
            grant       <= 4'b0000;
            grant_id    <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            ptr         <= ptr_nxt;
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            timeout     <= timeout_nxt;
        end
    end

    // FSM state for observation: 1 while a grant is outstanding.
    always_comb begin
        dbg_state = (state == BUSY);
    end

endmodule

// File: doc/arbiter_4req.md
# arbiter_4req

Four-requester arbiter that shares one downstream resource among requesters `req[3:0]`. It uses the same priority ordering as the team's 4:2 priority encoder, where index 3 is highest. The grant is registered and held until the owner releases or a hold timeout expires. A run-time mode input selects fixed-priority or round-robin arbitration. The block sits between the requesting agents and the shared datapath, and drives its select via `grant_id`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may be held; legal range 1..255.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  level requests, one bit per requester; the requester holds the bit high for as long as it needs the resource.
- `mode`  in  1  0 = fixed priority (req[3] highest, req[0] lowest), 1 = round-robin.
- `grant`  out  4  one-hot grant, all zero when idle.
- `grant_id`  out  2  index of the granted requester; 0 when idle.
- `grant_valid`  out  1  high whenever `grant` is non-zero.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- State machine with two states:
  - IDLE: no grant outstanding.
  - BUSY: one grant outstanding.
- IDLE, `req == 0`: stay in IDLE; all outputs zero.
- IDLE, `req != 0`: pick the winner, register `grant`, `grant_id` and `grant_valid`, load `hold_cnt = 1`, go to BUSY.
- Winner selection in fixed mode: the highest set index.
- Winner selection in round-robin mode:
  - Scan indices `ptr+1, ptr+2, ptr+3, ptr` (mod 4) and take the first set bit.
  - `ptr` is the last granted index.
  - `ptr` updates to the winner on every grant, in both modes.
- `mode` is sampled only at the IDLE arbitration edge. Changing it during BUSY has no effect on the current grant.
- BUSY, `req[grant_id]` low: release. `grant` goes to 0, state returns to IDLE, `timeout` stays 0.
- BUSY, `req[grant_id]` high and `hold_cnt == MAX_HOLD`: forced release. `grant` goes to 0, `timeout` pulses 1, state returns to IDLE.
- BUSY, otherwise: hold the grant and increment `hold_cnt`. `hold_cnt` width is 8 bits; it never wraps because it is bounded by `MAX_HOLD`.
- Requests from non-owners during BUSY are ignored. They are arbitrated at the next IDLE cycle.
- After a timeout in fixed mode, the same high-priority requester may win again; this is intended. Round-robin mode guarantees rotation.
- Reset values:
  - `grant = 0`, `grant_id = 0`, `grant_valid = 0`, `timeout = 0`.
  - State = IDLE, `hold_cnt = 0`.
  - `ptr = 3`, so the first round-robin scan starts at index 0.
- `rst` asserted mid-grant: on that edge all outputs go to their reset values, with no `timeout` pulse, and any owner is dropped.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Grant latency: `req` high in cycle c while IDLE, so `grant` is high from cycle c+1.
- Release latency: owner drops `req` in cycle c, so `grant` is 0 in cycle c+1.
- Turnaround: exactly one idle cycle, with `grant == 0`, between any two grants, including back-to-back grants to different requesters. The earliest next grant is in cycle c+2.
- Hold limit: `grant` is high for at most `MAX_HOLD` consecutive cycles. On the following cycle `grant = 0` and `timeout = 1`, for exactly one cycle.
- Simultaneous events: if the owner drops `req` in the same cycle that `hold_cnt == MAX_HOLD`, it is a normal release and `timeout = 0`.
- `grant_valid` always equals `|grant`, and `grant_id` always matches the one-hot `grant` bit.

## Test plan
- Reset mid-grant: in mode 0, `req=0100` for 3 cycles, then `rst` for 1 cycle with `req` still high → `grant=0000`, `timeout=0` on the reset cycle; `grant=0100` two cycles after `rst` falls.
- Fixed priority, all requesters: mode 0, `req=1111` held, `MAX_HOLD=8` → `grant=1000` for 8 cycles, then `grant=0000` with `timeout=1`, then `grant=1000` again.
- Round-robin rotation: mode 1 from reset, `req=1111`, each owner drops its bit 2 cycles after grant and reasserts it 1 cycle later → grant order is 0,1,2,3,0, with one idle cycle between grants.
- Round-robin skip: mode 1, `ptr=1` (after a grant to index 1), `req=1001` → winner is index 3, then index 0 on the next arbitration.
- Normal release vs. timeout: `MAX_HOLD=4`, `req=0010` held exactly 4 grant cycles, then dropped in the last one → `timeout` never asserts. Held 5 cycles → `timeout=1` in cycle 5.
- Mode change during BUSY: `mode` toggles while `grant=0100` → `grant` stays `0100` until release; the next arbitration uses the new `mode`.
